// File: rtl/mem_bus_initiator_if.sv
// Request/response handshake and memory pin bundle for mem_bus_initiator.
// The master modport is the initiator; the slave modport is core logic plus pads.
interface mem_bus_initiator_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              mem_ce_n;
    logic              mem_oe_n;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_dq_out;
    logic              mem_dq_oe;
    logic [DATA_W-1:0] mem_dq_in;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, mem_dq_in,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_ce_n, mem_oe_n, mem_we_n, mem_a, mem_dq_out, mem_dq_oe
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, mem_dq_in,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_ce_n, mem_oe_n, mem_we_n, mem_a, mem_dq_out, mem_dq_oe
    );
endinterface

// File: rtl/mem_bus_initiator.sv
// Turns single-cycle read/write requests into CE_/OE_/WE_ strobe sequences on an async memory bus.
// Read response RD_WAIT cycles after accept; req_ready stays low until the bus-turnaround cycle ends.
module mem_bus_initiator #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 5,   // 1..255
    parameter int WR_WAIT = 3    // 1..255
) (
    input  logic SIM_CLK,
    input  logic SIM_RST,
    mem_bus_initiator_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, TURN} state_t;

    localparam logic [7:0] RD_CNT = 8'(RD_WAIT - 1);
    localparam logic [7:0] WR_CNT = 8'(WR_WAIT - 1);

    state_t            state_q,  state_d;
    logic [7:0]        cnt_q,    cnt_d;
    logic              ready_q,  ready_d;
    logic              ce_n_q,   ce_n_d;
    logic              oe_n_q,   oe_n_d;
    logic              we_n_q,   we_n_d;
    logic [ADDR_W-1:0] a_q,      a_d;
    logic [DATA_W-1:0] dq_out_q, dq_out_d;
    logic              dq_oe_q,  dq_oe_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        a_d       = a_q;
        dq_out_d  = dq_out_q;
        dq_oe_d   = dq_oe_q;
        rsp_vld_d = 1'b0;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    a_d     = bus.req_addr;
                    ready_d = 1'b0;
                    ce_n_d  = 1'b0;
                    if (bus.req_we) begin
                        dq_out_d = bus.req_wdata;
                        dq_oe_d  = 1'b1;
                        state_d  = WR_SETUP;
                    end else begin
                        oe_n_d  = 1'b0;
                        cnt_d   = RD_CNT;
                        state_d = RD_ACC;
                    end
                end
            end
            RD_ACC: begin
                if (cnt_q == 8'd0) begin
                    rdata_d   = bus.mem_dq_in;
                    rsp_vld_d = 1'b1;
                    ce_n_d    = 1'b1;
                    oe_n_d    = 1'b1;
                    state_d   = TURN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            // Data is already on DQ one cycle before WE_ falls.
            WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = WR_CNT;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == 8'd0) begin
                    we_n_d  = 1'b1;
                    ce_n_d  = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WR_HOLD: begin
                dq_oe_d = 1'b0;
                state_d = TURN;
            end
            TURN: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            a_q       <= '0;
            dq_out_q  <= '0;
            dq_oe_q   <= 1'b0;
            rsp_vld_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            a_q       <= a_d;
            dq_out_q  <= dq_out_d;
            dq_oe_q   <= dq_oe_d;
            rsp_vld_q <= rsp_vld_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.rsp_valid  = rsp_vld_q;
    assign bus.rsp_rdata  = rdata_q;
    assign bus.mem_ce_n   = ce_n_q;
    assign bus.mem_oe_n   = oe_n_q;
    assign bus.mem_we_n   = we_n_q;
    assign bus.mem_a      = a_q;
    assign bus.mem_dq_out = dq_out_q;
    assign bus.mem_dq_oe  = dq_oe_q;

    // Bus-contention and strobe-ordering invariants.
    a_no_contention: assert property (@(posedge SIM_CLK) disable iff (!SIM_RST)
        !(!oe_n_q && dq_oe_q));
    a_we_in_ce: assert property (@(posedge SIM_CLK) disable iff (!SIM_RST)
        !(!we_n_q && ce_n_q));
    a_addr_stable: assert property (@(posedge SIM_CLK) disable iff (!SIM_RST)
        (!ce_n_q && $past(!ce_n_q)) |-> $stable(a_q));
    a_data_stable: assert property (@(posedge SIM_CLK) disable iff (!SIM_RST)
        (dq_oe_q && $past(dq_oe_q)) |-> $stable(dq_out_q));
endmodule

// File: tb/tb_mem_bus_initiator.sv
module tb_mem_bus_initiator;
    localparam int AW = 17;
    localparam int DW = 16;
    localparam int HALF = 5;      // 10-unit clock period
    localparam int ACC_T = 40;    // memory access time
    localparam int RDW = 5;
    localparam int WRW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #HALF clk = ~clk;

    mem_bus_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus5 ();
    mem_bus_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_bus_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut5 (
        .SIM_CLK(clk), .SIM_RST(rst_n), .bus(bus5));
    mem_bus_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(3), .WR_WAIT(WRW)) dut3 (
        .SIM_CLK(clk), .SIM_RST(rst_n), .bus(bus3));

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_d;

    // ROM image plus RAM overlay; erased/absent locations read as all ones.
    logic [DW-1:0] mem_img [int];
    function automatic logic [DW-1:0] img_rd(input logic [AW-1:0] a);
        if (mem_img.exists(int'(a))) return mem_img[int'(a)];
        return '1;
    endfunction

    // Device drives valid data only once ACC_T has elapsed since OE_ fell by the next sample edge.
    longint t5 = 0, t3 = 0;
    always @(negedge bus5.mem_oe_n) t5 = longint'($time);
    always @(negedge bus3.mem_oe_n) t3 = longint'($time);
    always @(negedge clk) begin
        bus5.mem_dq_in = (!bus5.mem_ce_n && !bus5.mem_oe_n &&
                          (longint'($time) + HALF - t5 >= ACC_T)) ? img_rd(bus5.mem_a) : '0;
        bus3.mem_dq_in = (!bus3.mem_ce_n && !bus3.mem_oe_n &&
                          (longint'($time) + HALF - t3 >= ACC_T)) ? img_rd(bus3.mem_a) : '0;
    end
    always @(posedge bus5.mem_we_n)
        if (bus5.mem_dq_oe === 1'b1) mem_img[int'(bus5.mem_a)] = bus5.mem_dq_out;

    int inv_viol = 0;
    always @(negedge clk) if (rst_n) begin
        if (!bus5.mem_oe_n && bus5.mem_dq_oe) inv_viol++;
        if (!bus5.mem_we_n && bus5.mem_ce_n) inv_viol++;
    end

    // Per-operation observations (j = negedges after the accept edge, starting at 0).
    int o_ce_lo, o_oe_lo, o_we_lo, o_we_first, o_we_last, o_dq_first, o_dq_last;
    int o_rsp_cnt, o_rsp_at, o_rdy_at;
    logic [DW-1:0] o_rd, o_dq_val;
    logic [AW-1:0] o_a0;

    // Caller is at a negedge; request is offered immediately.
    task automatic do_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        o_ce_lo = 0; o_oe_lo = 0; o_we_lo = 0; o_rsp_cnt = 0;
        o_we_first = -1; o_we_last = -1; o_dq_first = -1; o_dq_last = -1;
        o_rsp_at = -1; o_rdy_at = -1; o_rd = '0; o_dq_val = '0; o_a0 = '0;
        bus5.req_valid = 1'b1; bus5.req_we = we; bus5.req_addr = a; bus5.req_wdata = d;
        while (bus5.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin bus5.req_valid = 1'b0; return; end
        for (int j = 0; j < 40 && o_rdy_at < 0; j++) begin
            @(negedge clk);
            if (j == 0) begin bus5.req_valid = 1'b0; o_a0 = bus5.mem_a; end
            if (bus5.mem_ce_n === 1'b0) o_ce_lo++;
            if (bus5.mem_oe_n === 1'b0) o_oe_lo++;
            if (bus5.mem_we_n === 1'b0) begin
                o_we_lo++; o_we_last = j;
                if (o_we_first < 0) o_we_first = j;
            end
            if (bus5.mem_dq_oe === 1'b1) begin
                o_dq_last = j; o_dq_val = bus5.mem_dq_out;
                if (o_dq_first < 0) o_dq_first = j;
            end
            if (bus5.rsp_valid === 1'b1) begin o_rsp_cnt++; o_rsp_at = j; o_rd = bus5.rsp_rdata; end
            if (bus5.req_ready === 1'b1) o_rdy_at = j;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if ({bus5.mem_ce_n, bus5.mem_oe_n, bus5.mem_we_n} !== 3'b111) begin
            fails++; $display("FAIL reset_strobes: got %b expected 111", {bus5.mem_ce_n, bus5.mem_oe_n, bus5.mem_we_n}); end
        tests++; if ({bus5.mem_dq_oe, bus5.rsp_valid, bus5.req_ready} !== 3'b001) begin
            fails++; $display("FAIL reset_ctl: dq_oe/rsp_valid/req_ready got %b expected 001",
                              {bus5.mem_dq_oe, bus5.rsp_valid, bus5.req_ready}); end
        tests++; if (bus5.rsp_rdata !== 16'h0 || bus5.mem_a !== 17'h0 || bus5.mem_dq_out !== 16'h0) begin
            fails++; $display("FAIL reset_data: rdata %h a %h dq_out %h expected zeros",
                              bus5.rsp_rdata, bus5.mem_a, bus5.mem_dq_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_read_rom();
        exp_q.push_back(16'h1234);
        do_op(1'b0, 17'h0_0042, 16'h0);
        tests++; if (o_a0 !== 17'h0_0042) begin fails++; $display("FAIL rd_addr: got %h expected 00042", o_a0); end
        tests++; if (o_ce_lo != RDW || o_oe_lo != RDW) begin
            fails++; $display("FAIL rd_strobe_len: ce %0d oe %0d expected %0d", o_ce_lo, o_oe_lo, RDW); end
        tests++; if (o_rsp_cnt != 1 || o_rsp_at != RDW) begin
            fails++; $display("FAIL rd_rsp_timing: pulses %0d at %0d expected 1 at %0d", o_rsp_cnt, o_rsp_at, RDW); end
        exp_d = exp_q.pop_front();
        tests++; if (o_rd !== exp_d) begin fails++; $display("FAIL rd_data: got %h expected %h", o_rd, exp_d); end
        // Ready seen at RD_WAIT+1 means the next accept lands RD_WAIT+2 edges after this one.
        tests++; if (o_rdy_at != RDW + 1) begin fails++; $display("FAIL rd_ready: got %0d expected %0d", o_rdy_at, RDW + 1); end
        tests++; if (o_dq_first != -1) begin fails++; $display("FAIL rd_no_drive: dq_oe seen at %0d expected never", o_dq_first); end
    endtask

    task automatic test_read_absent();
        int r3_at = -1;
        logic [DW-1:0] r3 = '0;
        exp_q.push_back(16'hFFFF);
        do_op(1'b0, 17'h1_FFFF, 16'h0);
        exp_d = exp_q.pop_front();
        tests++; if (o_rsp_cnt != 1 || o_rd !== exp_d) begin
            fails++; $display("FAIL rd_absent: got %h (pulses %0d) expected %h", o_rd, o_rsp_cnt, exp_d); end
        // Same address on the RD_WAIT=3 instance samples before the device has valid data.
        exp_q.push_back(16'h0000);
        bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.req_addr = 17'h1_FFFF;
        for (int j = 0; j < 20 && r3_at < 0; j++) begin
            @(negedge clk);
            if (j == 0) bus3.req_valid = 1'b0;
            if (bus3.rsp_valid === 1'b1) begin r3_at = j; r3 = bus3.rsp_rdata; end
        end
        exp_d = exp_q.pop_front();
        tests++; if (r3_at != 3 || r3 !== exp_d) begin
            fails++; $display("FAIL rd_short_wait: got %h at %0d expected %h at 3", r3, r3_at, exp_d); end
        tests++; if (r3 === o_rd) begin
            fails++; $display("FAIL rd_wait_dependence: both waits sampled %h expected differing data", r3); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write_ram();
        do_op(1'b1, 17'h0_0100, 16'hA5A5);
        tests++; if (o_we_lo != WRW || o_we_first != 1 || o_we_last != WRW) begin
            fails++; $display("FAIL wr_we_pulse: len %0d from %0d to %0d expected %0d from 1 to %0d",
                              o_we_lo, o_we_first, o_we_last, WRW, WRW); end
        tests++; if (o_ce_lo != WRW + 1 || o_oe_lo != 0) begin
            fails++; $display("FAIL wr_ce_oe: ce %0d oe %0d expected %0d and 0", o_ce_lo, o_oe_lo, WRW + 1); end
        tests++; if (o_dq_first != 0 || o_dq_last != WRW + 1 || o_dq_val !== 16'hA5A5) begin
            fails++; $display("FAIL wr_dq_window: %0d..%0d data %h expected 0..%0d data a5a5",
                              o_dq_first, o_dq_last, o_dq_val, WRW + 1); end
        tests++; if (o_rsp_cnt != 0 || o_rdy_at != WRW + 3) begin
            fails++; $display("FAIL wr_rsp_ready: pulses %0d ready %0d expected 0 and %0d", o_rsp_cnt, o_rdy_at, WRW + 3); end
        tests++; if (bus5.rsp_rdata !== 16'hFFFF) begin
            fails++; $display("FAIL rdata_hold: got %h expected ffff", bus5.rsp_rdata); end
        exp_q.push_back(16'hA5A5);
        do_op(1'b0, 17'h0_0100, 16'h0);
        exp_d = exp_q.pop_front();
        tests++; if (o_rsp_cnt != 1 || o_rd !== exp_d) begin
            fails++; $display("FAIL wr_readback: got %h (pulses %0d) expected %h", o_rd, o_rsp_cnt, exp_d); end
    endtask

    task automatic test_back_to_back();
        int acc1 = -1, acc2 = -1, r_at = -1, v0 = inv_viol;
        logic [DW-1:0] r = '0;
        bus5.req_valid = 1'b1; bus5.req_we = 1'b1; bus5.req_addr = 17'h0_0001; bus5.req_wdata = 16'h5A5A;
        for (int n = 0; n < 60 && acc2 < 0; n++) begin
            if (bus5.req_ready === 1'b1) begin
                if (acc1 < 0) acc1 = n; else acc2 = n;
            end
            @(negedge clk);
            if (acc1 >= 0 && acc2 < 0 && bus5.req_we === 1'b1) begin
                bus5.req_we = 1'b0; bus5.req_wdata = 16'h0; exp_q.push_back(16'h5A5A);
            end
        end
        bus5.req_valid = 1'b0;
        tests++; if (acc1 < 0 || acc2 - acc1 != WRW + 4) begin
            fails++; $display("FAIL b2b_spacing: got %0d expected %0d", acc2 - acc1, WRW + 4); end
        for (int j = 0; j < 20 && r_at < 0; j++) begin
            if (bus5.rsp_valid === 1'b1) begin r_at = j; r = bus5.rsp_rdata; end
            else @(negedge clk);
        end
        exp_d = exp_q.pop_front();
        tests++; if (r_at < 0 || r !== exp_d) begin fails++; $display("FAIL b2b_readback: got %h expected %h", r, exp_d); end
        for (int j = 0; j < 20 && bus5.req_ready !== 1'b1; j++) @(negedge clk);
        tests++; if (inv_viol != v0) begin fails++; $display("FAIL invariants: %0d violations expected 0", inv_viol - v0); end
    endtask

    task automatic test_reset_mid_read();
        int rsp_seen = 0;
        bus5.req_valid = 1'b1; bus5.req_we = 1'b0; bus5.req_addr = 17'h0_0042;
        @(negedge clk);
        bus5.req_valid = 1'b0;
        @(negedge clk);
        tests++; if (bus5.mem_oe_n !== 1'b0) begin fails++; $display("FAIL rst_pre: oe_n got %b expected 0", bus5.mem_oe_n); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        tests++; if ({bus5.mem_ce_n, bus5.mem_oe_n, bus5.mem_we_n, bus5.mem_dq_oe} !== 4'b1110) begin
            fails++; $display("FAIL rst_async: strobes/dq_oe got %b expected 1110",
                              {bus5.mem_ce_n, bus5.mem_oe_n, bus5.mem_we_n, bus5.mem_dq_oe}); end
        repeat (6) begin @(negedge clk); if (bus5.rsp_valid !== 1'b0) rsp_seen++; end
        tests++; if (rsp_seen != 0 || bus5.rsp_rdata !== 16'h0) begin
            fails++; $display("FAIL rst_no_rsp: pulses %0d rdata %h expected 0 and 0000", rsp_seen, bus5.rsp_rdata); end
        rst_n = 1'b1;
        exp_q.push_back(16'h1234);
        do_op(1'b0, 17'h0_0042, 16'h0);
        exp_d = exp_q.pop_front();
        tests++; if (o_rsp_at != RDW || o_rd !== exp_d) begin
            fails++; $display("FAIL rst_recover: got %h at %0d expected %h at %0d", o_rd, o_rsp_at, exp_d, RDW); end
    endtask

    initial begin
        mem_img[32'h42] = 16'h1234;
        mem_img[32'h43] = 16'hBEEF;
        bus5.req_valid = 1'b0; bus5.req_we = 1'b0; bus5.req_addr = '0; bus5.req_wdata = '0;
        bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
        test_reset();
        test_read_rom();
        test_read_absent();
        test_write_ram();
        test_back_to_back();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected < 200000", $time);
        $fatal(1);
    end
endmodule
